truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that exhaustively drives a combinational boolean function block (inputs {p,q,r,s}, output t) through all 2^N_IN input vectors, waits a programmable settle time per vector, samples the output and assembles the observed truth table. It compares the observed table against an expected table latched at start and reports a mismatch mask, error count, first failing index and pass/fail. It sits beside the gate-level function block as its on-chip self-check controller, replacing the exhaustive sweep a testbench would otherwise perform.

## Interface

- N_IN, default 4: function input width; table width is 2^N_IN (16).
- SETTLE, default 2: extra cycles vec_out is held before sampling; legal range ≥ 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; accepted only in IDLE.
- abort  in  1  stop sweep; return to IDLE, no done pulse.
- expected  in  2^N_IN  expected table; bit i = t for vector i; latched on accepted start.
- vec_out  out  N_IN  drives function inputs, MSB = p … LSB = s.
- f_in  in  1  function output t.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse after the last sample.
- table_out  out  2^N_IN  observed table, bit i = sampled f_in for vector i.
- mismatch  out  2^N_IN  table_out XOR latched expected, per sampled bit.
- err_count  out  N_IN+1  number of mismatching vectors (0..16).
- first_fail  out  N_IN  lowest failing index; 0 if none.
- pass  out  1  valid from done onward: err_count == 0.

## Operation

- Reset: state IDLE; vec_out, busy, done, table_out, mismatch, err_count, first_fail, pass all 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on start=1, latch expected, clear table_out/mismatch/err_count/first_fail/pass, idx=0, vec_out=0, settle counter=0, busy=1. Next state is SETTLE, or SAMPLE if SETTLE=0.
- SETTLE: count to SETTLE-1, then go to SAMPLE.
- SAMPLE: table_out[idx] <= f_in; mismatch[idx] <= f_in ^ exp[idx].
  - On mismatch: err_count++. If this is the first error, first_fail <= idx.
  - If idx == 2^N_IN-1, go to DONE; vec_out holds 15.
  - Otherwise idx++, vec_out <= idx+1, go to SETTLE (or stay in SAMPLE if SETTLE=0).
- DONE: done=1, pass <= (final err_count==0), busy=0. Next state IDLE. vec_out returns to 0.
- abort: has priority over all transitions in every non-IDLE state. Next state IDLE, busy=0, vec_out=0, no done. Partial results are held; pass stays 0.
- Ignored inputs:
  - start while busy or in DONE.
  - start and abort together in IDLE: abort wins, start is ignored.
  - Changes on expected after the latch.
- Results hold until the next accepted start.
- err_count width N_IN+1 cannot saturate (max 2^N_IN).

## Timing

- Each vector is held for SETTLE+1 cycles; f_in is sampled on the last edge of that window.
- Start accepted at edge E0. Vector i is sampled at edge E0+(i+1)(SETTLE+1).
- done is high for exactly the cycle after edge E0+16(SETTLE+1). With SETTLE=2: last sample at E0+48, done between E0+48 and E0+49.
- Total latency start→done = 16(SETTLE+1)+1 cycles; the next start is accepted on the cycle after done.
- Reset asserted mid-sweep: immediate return to reset values, no done.

## Structure

- Shared package tt_pkg holds:
  - the FSM state encoding (IDLE/SETTLE/SAMPLE/DONE);
  - N_IN default and derived TBL_W = 1<<N_IN;
  - the constant TT_REF_MASK = 16'h4644, the truth table of t = pq'r's + rs'.
- One sub-module: tt_settle_timer, a loadable down-counter. It takes SETTLE and raises an expire flag; it is cleared by the FSM on each vector change and on abort.

## Test plan

- Correct function: instantiate the gate-level function, expected=16'h4644, SETTLE=2 → done at start+49, table_out=16'h4644, mismatch=0, err_count=0, pass=1.
- Single fault: expected=16'h4645 → mismatch=16'h0001, err_count=1, first_fail=0, pass=0.
- Stuck-at-1 f_in, expected=16'h4644 → table_out=16'hFFFF, mismatch=16'hB9BB, err_count=11, first_fail=0, pass=0.
- SETTLE=0 → vec_out steps 0..15 once per cycle, done at start+17. A start pulse during the sweep is ignored and the count is unchanged.
- abort asserted at vector 5 → busy falls next cycle, no done, vec_out=0. A later start performs a full clean sweep.
- rst_n low during vector 9 → all outputs 0 immediately. After release, the FSM stays in IDLE until start.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_pkg;

    // Default function input width and the resulting truth-table width.
    localparam int N_IN_DEF = 4;
    localparam int TBL_W    = 1 << N_IN_DEF;

    // Truth table of t = p q' r' s + r s', indexed by {p,q,r,s}.
    localparam logic [TBL_W-1:0] TT_REF_MASK = 16'h4644;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper and whoever controls it / hosts the function block.
// Latency: n/a (wires only).
// Backpressure: none; start is accepted only when the sweeper is idle.
// master: drives start/abort/expected and the function output f_in.
// slave : drives vec_out plus the status and result fields.
interface truth_table_sweeper_if
    import tt_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);
    localparam int TW = 1 << N_IN;

    logic            start;
    logic            abort;
    logic [TW-1:0]   expected;
    logic [N_IN-1:0] vec_out;
    logic            f_in;
    logic            busy;
    logic            done;
    logic [TW-1:0]   table_out;
    logic [TW-1:0]   mismatch;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            pass;

    modport master (
        output start, abort, expected, f_in,
        input  vec_out, busy, done, table_out, mismatch, err_count, first_fail, pass
    );

    modport slave (
        input  start, abort, expected, f_in,
        output vec_out, busy, done, table_out, mismatch, err_count, first_fail, pass
    );

endinterface

// File: rtl/tt_settle_timer.sv
// Settle-time down-counter; expire_o high once a vector has been held long enough.
// Latency: expire_o rises SETTLE-1 enabled cycles after clr_i.
// Backpressure: none; counter freezes at zero until cleared again.
// Ports: clk, rst_n; clr_i reloads the count; en_i decrements; expire_o = count is zero.
module tt_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The FSM's own SETTLE->SAMPLE transition consumes one cycle, so load SETTLE-1.
    localparam int LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CW'(LOAD);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweep of a combinational function with settle time and result compare.
// Latency: start->done = 2^N_IN*(SETTLE+1)+1 cycles; each vector held SETTLE+1 cycles.
// Backpressure: start ignored unless idle; abort returns to idle from any busy/done state.
// Ports: clk, rst_n (async active-low); bus = slave side of truth_table_sweeper_if
//        (start/abort/expected/f_in in; vec_out/busy/done/table_out/mismatch/err_count/first_fail/pass out).
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int TW = 1 << N_IN;
    localparam tt_state_e ST_AFTER_VEC = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic [TW-1:0]   tbl_q, tbl_d;
    logic [TW-1:0]   mis_q, mis_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            pass_q, pass_d;
    logic            tmr_clr, tmr_en, tmr_exp;
    logic            bit_mis;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_exp)
    );

    assign bit_mis = bus.f_in ^ exp_q[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        exp_d   = exp_q;
        tbl_d   = tbl_q;
        mis_d   = mis_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (bus.start && !bus.abort) begin
                    exp_d   = bus.expected;
                    tbl_d   = '0;
                    mis_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    vec_d   = '0;
                    tmr_clr = 1'b1;
                    state_d = ST_AFTER_VEC;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    vec_d   = '0;
                    tmr_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmr_exp) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    vec_d   = '0;
                    tmr_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tbl_d[idx_q] = bus.f_in;
                    mis_d[idx_q] = bit_mis;
                    if (bit_mis) begin
                        err_d = err_q + 1'b1;
                        // indices ascend, so the first error seen is the lowest one
                        if (err_q == '0) begin
                            ff_d = idx_q;
                        end
                    end
                    if (&idx_q) begin
                        // pass is resolved here so it is already valid while done is high
                        pass_d  = (err_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        vec_d   = idx_q + 1'b1;
                        tmr_clr = 1'b1;
                        state_d = ST_AFTER_VEC;
                    end
                end
            end
            ST_DONE: begin
                vec_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                vec_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            exp_q   <= '0;
            tbl_q   <= '0;
            mis_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            tbl_q   <= tbl_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec_out    = vec_q;
    assign bus.busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.table_out  = tbl_q;
    assign bus.mismatch   = mis_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
    assign bus.pass       = pass_q;

endmodule
